// File: rtl/mem_stage_if.sv
// mem_stage_if: handshake and bus bundle around the memory-access stage.
//   exe_to_mem_bus   : {regW, regAddr, aluResult, load_inst} from execute
//   exe_to_mem_valid : execute entry valid
//   mem_to_exe_ready : memory stage can accept
//   load_data        : aligned memory word, valid in the cycle after acceptance
//   mem_to_wb_bus    : {regW, regAddr, wb_data} toward writeback
//   mem_to_wb_valid  : entry valid toward writeback
//   wb_to_mem_ready  : writeback can accept
//   mem_fw_bus       : {fw_we, regAddr, wb_data} forwarding toward decode
// Modports: slave = the memory stage, master = its environment.
interface mem_stage_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH+ADDR_WIDTH+3:0] exe_to_mem_bus;
  logic                             exe_to_mem_valid;
  logic                             mem_to_exe_ready;
  logic [DATA_WIDTH-1:0]            load_data;
  logic [DATA_WIDTH+ADDR_WIDTH:0]   mem_to_wb_bus;
  logic                             mem_to_wb_valid;
  logic                             wb_to_mem_ready;
  logic [DATA_WIDTH+ADDR_WIDTH:0]   mem_fw_bus;

  modport slave (
    input  exe_to_mem_bus, exe_to_mem_valid, load_data, wb_to_mem_ready,
    output mem_to_exe_ready, mem_to_wb_bus, mem_to_wb_valid, mem_fw_bus
  );

  modport master (
    output exe_to_mem_bus, exe_to_mem_valid, load_data, wb_to_mem_ready,
    input  mem_to_exe_ready, mem_to_wb_bus, mem_to_wb_valid, mem_fw_bus
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Registers the execute result, formats the aligned load word (lane select
// plus sign/zero extension), forwards {regW, regAddr, wb_data} to writeback
// and drives the decode forwarding bus.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-low
//   bus  : mem_stage_if.slave (execute/writeback handshakes, load_data, fw bus)
// Optional build macro MEM_STAGE_PERF_EN adds perf_load_cnt / perf_stall_cnt.
module mem_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_stage_if.slave   bus
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0]  perf_load_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);

  // FRESH: load_data is the live word; HELD: word captured on stall entry.
  typedef enum logic {HELD = 1'b0, FRESH = 1'b1} word_state_e;

  logic                  in_regw;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_alu;
  logic [2:0]            in_ld;

  logic                  valid_q, valid_d;
  word_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  regw_q, regw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic [2:0]            ld_q, ld_d;

  logic                  ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_WIDTH-1:0] wb_data;

  assign {in_regw, in_addr, in_alu, in_ld} = bus.exe_to_mem_bus;

  assign ready  = ~valid_q | bus.wb_to_mem_ready;
  assign accept = bus.exe_to_mem_valid & ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      state_q <= HELD;
      hold_q  <= '0;
      regw_q  <= 1'b0;
      addr_q  <= '0;
      alu_q   <= '0;
      ld_q    <= '0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      regw_q  <= regw_d;
      addr_q  <= addr_d;
      alu_q   <= alu_d;
      ld_q    <= ld_d;
    end
  end

  always_comb begin
    valid_d = valid_q;
    state_d = state_q;
    hold_d  = hold_q;
    regw_d  = regw_q;
    addr_d  = addr_q;
    alu_d   = alu_q;
    ld_d    = ld_q;
    if (accept) begin
      valid_d = 1'b1;
      state_d = FRESH;
      regw_d  = in_regw;
      addr_d  = in_addr;
      alu_d   = in_alu;
      ld_d    = in_ld;
    end else if (bus.wb_to_mem_ready) begin
      valid_d = 1'b0;
    end
    // load_data is only guaranteed for one cycle: capture it when a stall begins.
    if (state_q == FRESH && valid_q && !bus.wb_to_mem_ready) begin
      hold_d  = bus.load_data;
      state_d = HELD;
    end
  end

  assign word = (state_q == FRESH) ? bus.load_data : hold_q;

  always_comb begin
    lane_b = word[7:0];
    case (alu_q[1:0])
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = alu_q[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    wb_data = alu_q;
    case (ld_q)
      3'b001:  wb_data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      3'b010:  wb_data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      3'b011:  wb_data = word;
      3'b100:  wb_data = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      3'b101:  wb_data = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      default: wb_data = alu_q;
    endcase
  end

  assign bus.mem_to_exe_ready = ready;
  assign bus.mem_to_wb_valid  = valid_q;
  assign bus.mem_to_wb_bus    = {regw_q, addr_q, wb_data};
  assign bus.mem_fw_bus       = {valid_q & regw_q, addr_q, wb_data};

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        in_is_load;

  assign in_is_load = (in_ld >= 3'b001) && (in_ld <= 3'b101);

  always_comb begin
    load_cnt_d  = load_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept && in_is_load)
      load_cnt_d = load_cnt_q + 32'd1;
    if (valid_q && !bus.wb_to_mem_ready)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      load_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_load_cnt  = load_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a scoreboard of expected
// writeback bus values and immediate-assertion checks.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) mif ();

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] perf_load_cnt, perf_stall_cnt;
`endif

  mem_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
`ifdef MEM_STAGE_PERF_EN
    ,
    .perf_load_cnt  (perf_load_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [37:0] sb_q[$];
  logic        pend_v = 1'b0;
  logic        pend_rw;
  logic [4:0]  pend_ra;
  logic [31:0] pend_alu;
  logic [2:0]  pend_ld;
  logic        stall_prev = 1'b0;
  logic [37:0] prev_bus;

  function automatic logic [37:0] model(input logic rw, input logic [4:0] ra,
                                        input logic [31:0] alu, input logic [2:0] ld,
                                        input logic [31:0] w);
    logic [31:0] d;
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> (alu[1:0] * 8);
    b  = sh[7:0];
    sh = w >> (alu[1] ? 16 : 0);
    h  = sh[15:0];
    case (ld)
      3'd1:    d = {{24{b[7]}}, b};
      3'd2:    d = {{16{h[15]}}, h};
      3'd3:    d = w;
      3'd4:    d = {24'd0, b};
      3'd5:    d = {16'd0, h};
      default: d = alu;
    endcase
    return {rw, ra, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] ra,
                       input logic [31:0] alu, input logic [2:0] ld);
    mif.exe_to_mem_valid = v;
    mif.exe_to_mem_bus   = {rw, ra, alu, ld};
  endtask

  // One clock: scoreboard bookkeeping at the negedge, inputs stay as driven.
  task automatic tick();
    logic [37:0] e;
    @(negedge clk);
    if (pend_v) begin
      sb_q.push_back(model(pend_rw, pend_ra, pend_alu, pend_ld, mif.load_data));
      pend_v = 1'b0;
    end
    if (stall_prev && mif.mem_to_wb_valid)
      chk("stall_stable", {26'd0, mif.mem_to_wb_bus}, {26'd0, prev_bus});
    if (mif.mem_to_wb_valid && mif.wb_to_mem_ready && rst) begin
      if (sb_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL sb_underflow observed=%0h expected=none", mif.mem_to_wb_bus);
      end else begin
        e = sb_q.pop_front();
        chk("sb_wb_bus", {26'd0, mif.mem_to_wb_bus}, {26'd0, e});
      end
    end
    stall_prev = mif.mem_to_wb_valid && !mif.wb_to_mem_ready;
    prev_bus   = mif.mem_to_wb_bus;
    if (rst && mif.exe_to_mem_valid && mif.mem_to_exe_ready) begin
      {pend_rw, pend_ra, pend_alu, pend_ld} = mif.exe_to_mem_bus;
      pend_v = 1'b1;
    end
    @(posedge clk);
    if (!rst) begin
      sb_q.delete();
      pend_v     = 1'b0;
      stall_prev = 1'b0;
    end
    #1;
  endtask

  initial begin
    mif.wb_to_mem_ready = 1'b1;
    mif.load_data       = 32'h0;
    drive(1'b1, 1'b1, 5'd3, 32'h77, 3'd0);

    // Reset held two edges with an upstream entry offered.
    @(posedge clk); #1;
    chk("rst_valid0", {63'd0, mif.mem_to_wb_valid}, 64'd0);
    chk("rst_fw_we0", {63'd0, mif.mem_fw_bus[37]}, 64'd0);
    chk("rst_bus0",   {26'd0, mif.mem_to_wb_bus}, 64'd0);
    tick();
    chk("rst_valid1", {63'd0, mif.mem_to_wb_valid}, 64'd0);
    chk("rst_fw_we1", {63'd0, mif.mem_fw_bus[37]}, 64'd0);
    rst = 1'b1;
    tick();
    chk("first_accept", {63'd0, mif.mem_to_wb_valid}, 64'd1);
    chk("first_data",   {32'd0, mif.mem_to_wb_bus[31:0]}, 64'h77);

    // LB sign-extension from byte lane 3.
    drive(1'b1, 1'b1, 5'd7, 32'h8000_0003, 3'd1);
    mif.load_data = 32'h80AB_CDEF;
    tick();
    chk("lb_bus", {26'd0, mif.mem_to_wb_bus}, {26'd0, 1'b1, 5'd7, 32'hFFFF_FF80});

    // LHU / LH upper half, LW ignoring low address bits.
    mif.load_data = 32'h9234_5678;
    drive(1'b1, 1'b1, 5'd9, 32'h1000_0002, 3'd5);
    tick();
    chk("lhu", {32'd0, mif.mem_to_wb_bus[31:0]}, 64'h0000_9234);
    drive(1'b1, 1'b1, 5'd9, 32'h1000_0002, 3'd2);
    tick();
    chk("lh", {32'd0, mif.mem_to_wb_bus[31:0]}, 64'hFFFF_9234);
    drive(1'b1, 1'b1, 5'd9, 32'h1000_0001, 3'd3);
    tick();
    chk("lw", {32'd0, mif.mem_to_wb_bus[31:0]}, 64'h9234_5678);
    drive(1'b1, 1'b1, 5'd10, 32'h1000_0001, 3'd4);
    tick();
    chk("lbu", {32'd0, mif.mem_to_wb_bus[31:0]}, 64'h0000_0056);

    // Stall capture: word must survive load_data changing.
    drive(1'b1, 1'b1, 5'd11, 32'h2000_0000, 3'd3);
    mif.load_data = 32'h1111_1111;
    tick();
    mif.wb_to_mem_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd12, 32'h55, 3'd0);
    tick();
    mif.load_data = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready0", {63'd0, mif.mem_to_exe_ready}, 64'd0);
      chk("stall_word",   {32'd0, mif.mem_to_wb_bus[31:0]}, 64'h1111_1111);
      if (i < 2) tick();
    end
    mif.wb_to_mem_ready = 1'b1;
    tick();
    chk("after_stall", {32'd0, mif.mem_to_wb_bus[31:0]}, 64'h55);

    // Back-to-back ALU entries with no bubble.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 5'd1, i, 3'd0);
      tick();
      chk("b2b_valid", {63'd0, mif.mem_to_wb_valid}, 64'd1);
      chk("b2b_data",  {32'd0, mif.mem_to_wb_bus[31:0]}, i);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 3'd0);
    tick();
    chk("drain_valid0", {63'd0, mif.mem_to_wb_valid}, 64'd0);
    chk("drain_ready1", {63'd0, mif.mem_to_exe_ready}, 64'd1);

    // Forwarding bus.
    drive(1'b1, 1'b1, 5'd5, 32'h42, 3'd0);
    tick();
    chk("fw_bus", {26'd0, mif.mem_fw_bus}, {26'd0, 1'b1, 5'd5, 32'h42});
    drive(1'b1, 1'b0, 5'd5, 32'h42, 3'd0);
    tick();
    chk("fw_we_regw0", {63'd0, mif.mem_fw_bus[37]}, 64'd0);

    // Reserved load encoding behaves as no load.
    drive(1'b1, 1'b1, 5'd6, 32'hDEAD_BEEF, 3'd6);
    mif.load_data = 32'h0;
    tick();
    chk("ld110_alu", {32'd0, mif.mem_to_wb_bus[31:0]}, 64'hDEAD_BEEF);

    // Reset while an entry is stalled.
    mif.wb_to_mem_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd8, 32'h99, 3'd0);
    tick();
    chk("pre_rst_valid", {63'd0, mif.mem_to_wb_valid}, 64'd1);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 3'd0);
    rst = 1'b0;
    tick();
    chk("midrst_valid0", {63'd0, mif.mem_to_wb_valid}, 64'd0);
    rst = 1'b1;
    mif.wb_to_mem_ready = 1'b1;
    tick();
    tick();
    chk("sb_empty", {32'd0, 32'(sb_q.size())}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
